dm_subword_ctrl: RTL
====================

Name: dm_subword_ctrl

Overview:
- Memory-stage controller between the M-stage store/load request and a single-port synchronous data SRAM.
- Performs loads with byte/half extraction and sign/zero extension.
- Word stores complete in a single cycle.
- Byte and half stores use a two-cycle read-merge-write: read the old word, merge the new lanes, write back.
- Raises busy to stall the pipeline during the merge cycle and the load-return cycle.
- Flags misaligned accesses instead of touching memory.

Parameters:
- AW, 10, SRAM word-address width (depth 2^AW words of 32 bits)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- busy  out  1  stall request to the pipeline; high in every state other than IDLE
- rdata_valid  out  1  load result valid this cycle
- rdata  out  32  extended load result; 0 when rdata_valid = 0
- align_err  out  1  one-cycle pulse for a misaligned request
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  AW  SRAM word address
- mem_wdata  out  32  SRAM write word
- mem_rdata  in  32  SRAM read word, valid the cycle after a read (mem_en=1, mem_we=0)

Behaviour:
- States: IDLE, MERGE, LOAD, ERR.
- Accept = req_valid and state == IDLE. Requests are ignored in any other state; upstream holds them while busy = 1.
- Lanes are little-endian:
  - addr[1:0] = 00 selects [7:0], 01 [15:8], 10 [23:16], 11 [31:24].
  - Half with addr[1] = 0 selects [15:0]; addr[1] = 1 selects [31:16].
- Misaligned: half with addr[0] = 1; word with addr[1:0] != 00; size 11.
  - Accepting a misaligned request drives no mem_en and moves to ERR.
  - ERR: align_err = 1, busy = 1, no memory access; then IDLE.
- Word store accepted in IDLE:
  - Same cycle: mem_en = 1, mem_we = 1, mem_addr = req_addr[AW+1:2], mem_wdata = req_wdata.
  - Stay in IDLE; busy stays 0.
- Byte/half store accepted in IDLE:
  - Same cycle: read issued (mem_en = 1, mem_we = 0, mem_addr = word address).
  - Latch word address, lane offset, size and wdata; go to MERGE.
  - MERGE: mem_en = 1, mem_we = 1, same address. mem_wdata = mem_rdata with only the selected lane(s) replaced by wdata[7:0] or wdata[15:0]; all other bits preserved. Then IDLE.
- Load accepted in IDLE:
  - Same cycle: read issued; latch offset, size and unsigned flag; go to LOAD.
  - LOAD: rdata_valid = 1; rdata = selected lane of mem_rdata, sign- or zero-extended to 32 bits (word loads pass through unchanged). Then IDLE.
- Latency: load data appears 1 cycle after accept; sub-word store writes 1 cycle after accept; word store writes in the accept cycle.
- Outputs outside their active states are 0: mem_en, mem_we, mem_addr, mem_wdata, rdata, rdata_valid, align_err.
- Reset: while reset = 1, state goes to IDLE and all outputs are 0. Reset takes priority in any state.
  - A store in MERGE during reset is dropped; no write occurs.
  - A load in LOAD during reset produces no rdata_valid.
  - req_valid during a reset cycle is not accepted.
- Back-to-back:
  - A request presented in the cycle the FSM returns to IDLE is accepted in that IDLE cycle.
  - A load following a MERGE to the same word reads the merged value, because the write completes before the read is issued.

Test Plan:
- Word store then load: sw 0x12345678 @0x10, next cycle lw @0x10 -> write in cycle 0 with busy = 0; rdata = 0x12345678 with rdata_valid one cycle after load accept.
- Byte merge: memory @0x20 = 0xAABBCCDD, sb wdata 0x000000EE @0x22 -> busy = 1 for one cycle; MERGE writes 0xAAEECCDD; a following lbu @0x22 returns 0x000000EE and lb returns 0xFFFFFFEE.
- Half merge and extension: word 0x11112222, sh 0x8001 @0x2 -> 0x80012222; lh @0x2 -> 0xFFFF8001; lhu @0x2 -> 0x00008001.
- Misalignment: lw @0x1, sh @0x3, size 11 -> each yields align_err pulse with busy = 1 for one cycle and mem_en = 0 throughout; memory unchanged.
- Reset mid-merge: sb @0x4 accepted, reset asserted in MERGE cycle -> no mem_we, state IDLE, all outputs 0; word at 0x4 unchanged.
- Busy hold: hold lhu request during busy after sb -> exactly one MERGE write and one LOAD return; no duplicate accepts.

Source files
------------

// File: rtl/dm_subword_ctrl.sv
// Memory-stage data SRAM controller: word stores in one cycle, byte/half stores
// by read-merge-write, loads with lane extraction and sign/zero extension.
module dm_subword_ctrl #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          busy,
  output logic          rdata_valid,
  output logic [31:0]   rdata,
  output logic          align_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  // Handshake: a request is taken in any cycle where req_valid = 1 and busy = 0
  // (state IDLE, not in reset); while busy = 1 upstream must hold the request.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    LOAD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] addr_q;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [15:0]   wdata_q;

  logic          accept;
  logic          misaligned;
  logic [31:0]   merged;
  logic [31:0]   extracted;
  logic          unused_ok;

  assign unused_ok  = ^{req_addr[31:AW+2], req_wdata[31:16]};
  assign accept     = req_valid && (state_q == IDLE) && !reset;
  assign misaligned = (req_size == 2'b11) ||
                      ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && !misaligned) begin
        addr_q  <= req_addr[AW+1:2];
        off_q   <= req_addr[1:0];
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata[15:0];
      end
    end
  end

  // Replace only the addressed lane(s) of the old word.
  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      case (off_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = mem_rdata[7:0];
    h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (off_q)
      2'd0:    b = mem_rdata[7:0];
      2'd1:    b = mem_rdata[15:8];
      2'd2:    b = mem_rdata[23:16];
      default: b = mem_rdata[31:24];
    endcase
    case (size_q)
      2'b00:   extracted = {{24{b[7] & ~uns_q}}, b};
      2'b01:   extracted = {{16{h[15] & ~uns_q}}, h};
      default: extracted = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    rdata_valid = 1'b0;
    rdata       = '0;
    align_err   = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (reset) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (misaligned) begin
              state_d = ERR;
            end else if (req_we && (req_size == 2'b10)) begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = req_addr[AW+1:2];
              mem_wdata = req_wdata;
            end else begin
              mem_en   = 1'b1;
              mem_addr = req_addr[AW+1:2];
              state_d  = req_we ? MERGE : LOAD;
            end
          end
        end
        MERGE: begin
          busy      = 1'b1;
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = merged;
          state_d   = IDLE;
        end
        LOAD: begin
          busy        = 1'b1;
          rdata_valid = 1'b1;
          rdata       = extracted;
          state_d     = IDLE;
        end
        default: begin
          busy      = 1'b1;
          align_err = 1'b1;
          state_d   = IDLE;
        end
      endcase
    end
  end

endmodule
